// File: rtl/sia_pkg.sv
// sia_pkg: shared defaults and receiver state type for the SIA receive path.
package sia_pkg;
  localparam int SIA_DATA_WIDTH      = 16;
  localparam int SIA_BAUD_RATE_WIDTH = 32;
  localparam int SIA_FIFO_DEPTH      = 4;
  typedef enum logic {RX_IDLE, RX_ACTIVE} rx_state_e;
endpackage

// File: rtl/sia_rx_fifo_if.sv
// sia_rx_fifo_if: receive FIFO head word with valid/ready pop handshake.
interface sia_rx_fifo_if
  import sia_pkg::*;
#(
  parameter int DATA_WIDTH  = SIA_DATA_WIDTH,
  parameter int LEVEL_WIDTH = $clog2(SIA_FIFO_DEPTH) + 1
);
  logic [DATA_WIDTH-1:0]  dat_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [LEVEL_WIDTH-1:0] level_o;
  modport master (output dat_o, valid_o, level_o, input ready_i);
  modport slave  (input dat_o, valid_o, level_o, output ready_i);
endinterface

// File: rtl/sia_rx_sync_fifo.sv
// sia_rx_sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop.
module sia_rx_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic             w_wr, w_rd;
  assign o_level = LW'(r_wr - r_rd);
  assign o_empty = r_wr == r_rd;
  assign o_full  = o_level == LW'(DEPTH);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_wr);
      r_rd <= r_rd + (AW+1)'(w_rd);
    end
  always_ff @(posedge clk_i)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/sia_rx_fifo.sv
// sia_rx_fifo: SIA bit-serial receiver feeding a word FIFO with sticky overrun.
// Define SIA_RX_MAJORITY_VOTE_EN to take each bit as the majority of three consecutive samples.
module sia_rx_fifo
  import sia_pkg::*;
#(
  parameter int DATA_WIDTH      = SIA_DATA_WIDTH,
  parameter int BAUD_RATE_WIDTH = SIA_BAUD_RATE_WIDTH,
  parameter int FIFO_DEPTH      = SIA_FIFO_DEPTH,
  parameter int LEVEL_WIDTH     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [5:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       eedd_i,
  input  logic                       eedc_i,
  input  logic                       msbf_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  input  logic                       clr_ovr_i,
  output logic                       idle_o,
  output logic                       overrun_o,
  output logic                       sample_to,
  sia_rx_fifo_if.master              rx
);
  logic [1:0]                 r_rxd_s, r_rxc_s;
  logic                       r_d0, r_d1, r_c0, r_c1;
  rx_state_e                  r_state, w_state_nx;
  logic [BAUD_RATE_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0]      r_shift, w_shift_nx, w_shifted, w_mask;
  logic [5:0]                 r_len, w_len_nx, r_left, w_left_nx;
  logic                       r_msbf, w_msbf_nx, r_push, w_push_nx, r_ovr;
  logic                       w_edge, w_bit, w_pop, w_full, w_empty;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_rxd_s <= 2'b11;
      r_rxc_s <= 2'b11;
      {r_d0, r_d1, r_c0, r_c1} <= 4'hf;
    end else begin
      r_rxd_s <= {r_rxd_s[0], rxd_i};
      r_rxc_s <= {r_rxc_s[0], rxc_i};
      r_d0    <= r_rxd_s[1];
      r_d1    <= r_d0;
      r_c0    <= r_rxc_s[1];
      r_c1    <= r_c0;
    end
  assign w_edge = (eedd_i & (r_d0 ^ r_d1)) | (eedc_i & r_c0 & ~r_c1);
`ifdef SIA_RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) r_hist <= 2'b11;
    else           r_hist <= {r_hist[0], r_d0};
  // History holds d0 from the counter==2 and counter==1 cycles when counting uninterrupted
  assign w_bit = (baud_i >= 2) ? ((r_hist[1] & r_hist[0]) | (r_hist[1] & r_d0) | (r_hist[0] & r_d0))
                               : r_d0;
`else
  assign w_bit = r_d0;
`endif
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << r_len);
  assign w_shifted = r_msbf ? {r_shift[DATA_WIDTH-2:0], w_bit}
                            : (r_shift >> 1) | (DATA_WIDTH'(w_bit) << (r_len - 6'd1));
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_len_nx   = r_len;
    w_left_nx  = r_left;
    w_msbf_nx  = r_msbf;
    w_push_nx  = 1'b0;
    sample_to  = 1'b0;
    if (r_state == RX_IDLE) begin
      w_cnt_nx = baud_i;
      if (w_edge && bits_i != 6'd0) begin
        w_state_nx = RX_ACTIVE;
        w_len_nx   = (bits_i > 6'(DATA_WIDTH)) ? 6'(DATA_WIDTH) : bits_i;
        w_left_nx  = w_len_nx;
        w_msbf_nx  = msbf_i;
        w_shift_nx = '0;
        w_cnt_nx   = baud_i >> 1;
      end
    end else if (w_edge) begin
      w_cnt_nx = baud_i >> 1;
    end else if (r_cnt == '0) begin
      sample_to  = 1'b1;
      w_shift_nx = w_shifted & w_mask;
      w_left_nx  = r_left - 6'd1;
      w_cnt_nx   = baud_i;
      w_state_nx = (r_left == 6'd1) ? RX_IDLE : RX_ACTIVE;
      w_push_nx  = r_left == 6'd1;
    end else begin
      w_cnt_nx = r_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_state <= RX_IDLE;
      r_cnt   <= baud_i;
      r_shift <= '0;
      r_len   <= '0;
      r_left  <= '0;
      r_msbf  <= 1'b0;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_len   <= w_len_nx;
      r_left  <= w_left_nx;
      r_msbf  <= w_msbf_nx;
      r_push  <= w_push_nx;
    end
  assign w_pop = ~w_empty & rx.ready_i;
  // Set wins over clear
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni)                      r_ovr <= 1'b0;
    else if (r_push && w_full && !w_pop) r_ovr <= 1'b1;
    else if (clr_ovr_i)                  r_ovr <= 1'b0;
  sia_rx_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .LW(LEVEL_WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_shift),
    .o_dout  (rx.dat_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (rx.level_o)
  );
  assign rx.valid_o = ~w_empty;
  assign idle_o     = r_state == RX_IDLE;
  assign overrun_o  = r_ovr;
endmodule

// File: tb/tb_sia_rx_fifo.sv
// tb_sia_rx_fifo: scoreboard bench serialising words into sia_rx_fifo and checking FIFO pops.
module tb_sia_rx_fifo;
  logic        clk = 0, reset_ni = 0;
  logic [5:0]  bits_i = 0;
  logic [31:0] baud_i = 9;
  logic        eedd_i = 1, eedc_i = 0, msbf_i = 0, rxd_i = 1, rxc_i = 0, clr_ovr_i = 0;
  logic        idle_o, overrun_o, sample_to;
  int          n_chk = 0, n_fail = 0, n_samp = 0;
  logic [15:0] sb[$];
  logic [15:0] words[4] = '{16'h1234, 16'hBEEF, 16'h8001, 16'h7FFE};
  logic [15:0] fill[4]  = '{16'h0F0F, 16'h1111, 16'h2222, 16'h3333};

  sia_rx_fifo_if #(.DATA_WIDTH(16), .LEVEL_WIDTH(3)) rx ();

  sia_rx_fifo #(.DATA_WIDTH(16), .BAUD_RATE_WIDTH(32), .FIFO_DEPTH(4), .LEVEL_WIDTH(3)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bits_i   (bits_i),
    .baud_i   (baud_i),
    .eedd_i   (eedd_i),
    .eedc_i   (eedc_i),
    .msbf_i   (msbf_i),
    .rxd_i    (rxd_i),
    .rxc_i    (rxc_i),
    .clr_ovr_i(clr_ovr_i),
    .idle_o   (idle_o),
    .overrun_o(overrun_o),
    .sample_to(sample_to),
    .rx       (rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wmask(input int n);
    return (n >= 16) ? 16'hFFFF : 16'((1 << n) - 1);
  endfunction

  always @(negedge clk) if (sample_to) n_samp++;

  always @(negedge clk)
    if (reset_ni && rx.valid_o && rx.ready_i) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("pop_word", rx.dat_o, sb.pop_front());
    end

  // Each bit starts with an RXC rising edge and a change of RXD to the bit value
  task automatic send_word(input logic [15:0] val, input int n, input logic msb, input int per,
                           input bit keep);
    int s0;
    bits_i = 0;
    msbf_i = msb;
    rxd_i  = ~(msb ? val[n-1] : val[0]);
    repeat (6) @(posedge clk);
    #1;
    bits_i = 6'(n);
    if (keep) sb.push_back(val & wmask(n));
    s0 = n_samp;
    for (int i = 0; i < n; i++) begin
      rxd_i = msb ? val[n-1-i] : val[i];
      rxc_i = 1;
      repeat (per / 2) @(posedge clk);
      #1 rxc_i = 0;
      repeat (per - per / 2) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("sample_count", n_samp - s0, n);
  endtask

  task automatic send_with_pop(input logic [15:0] val);
    int s, k;
    s = n_samp;
    k = 0;
    fork
      send_word(val, 16, 0, 10, 1);
      begin
        while (n_samp < s + 16 && k < 1000) begin
          @(posedge clk);
          k++;
        end
        chk("pop_sync_timeout", k < 1000, 1);
        #1 rx.ready_i = 1;
        @(posedge clk);
        #1 rx.ready_i = 0;
      end
    join
  endtask

  task automatic drain(input int n);
    rx.ready_i = 1;
    repeat (n) @(posedge clk);
    #1 rx.ready_i = 0;
    chk("drain_valid", rx.valid_o, 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rx.ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx.valid_o, 0);
    chk("rst_level", rx.level_o, 0);
    chk("rst_dat", rx.dat_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_sample", sample_to, 0);
    reset_ni = 1;
    repeat (3) @(posedge clk);
    #1;
    send_word(16'h00A5, 8, 0, 10, 1);
    chk("lsb_valid", rx.valid_o, 1);
    chk("lsb_level", rx.level_o, 1);
    chk("lsb_dat", rx.dat_o, 16'h00A5);
    drain(1);
    send_word(16'h0016, 5, 1, 10, 1);
    chk("msb_dat", rx.dat_o, 16'h0016);
    drain(1);
    eedd_i = 0;
    eedc_i = 1;
    for (int i = 0; i < 4; i++) send_word(words[i], 16, i[0], 10, 1);
    chk("full_level", rx.level_o, 4);
    chk("full_ovr", overrun_o, 0);
    send_word(16'hDEAD, 16, 0, 10, 0);
    chk("ovr_set", overrun_o, 1);
    chk("ovr_level", rx.level_o, 4);
    chk("ovr_head", rx.dat_o, 16'h1234);
    clr_ovr_i = 1;
    @(posedge clk);
    #1 clr_ovr_i = 0;
    chk("ovr_clr", overrun_o, 0);
    drain(4);
    for (int i = 0; i < 4; i++) send_word(fill[i], 16, 0, 10, 1);
    send_with_pop(16'h4444);
    chk("pp_ovr", overrun_o, 0);
    chk("pp_level", rx.level_o, 4);
    drain(4);
    send_word(16'h003C, 8, 0, 13, 1);
    chk("resync_dat", rx.dat_o, 16'h003C);
    drain(1);
    bits_i = 0;
    rxd_i  = 0;
    repeat (6) @(posedge clk);
    #1 bits_i = 8;
    for (int i = 0; i < 3; i++) begin
      rxd_i = i[0];
      rxc_i = 1;
      repeat (5) @(posedge clk);
      #1 rxc_i = 0;
      repeat (5) @(posedge clk);
      #1;
    end
    chk("mid_busy", idle_o, 0);
    reset_ni = 0;
    rxd_i    = 1;
    rxc_i    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_idle", idle_o, 1);
    chk("mid_rst_valid", rx.valid_o, 0);
    chk("mid_rst_sample", sample_to, 0);
    reset_ni = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_valid", rx.valid_o, 0);
    chk("post_rst_level", rx.level_o, 0);
    chk("post_rst_idle", idle_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
